// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM command controller: command word layout,
// opcodes, FSM state encoding and opcode classification helpers.
// The SPI front end imports the same field positions to assemble commands.
package sram_ctrl_pkg;

    // Command word layout: [27:25] opcode, [24:8] address, [7:0] write data
    localparam int CMD_W    = 28;
    localparam int OPC_MSB  = 27;
    localparam int OPC_LSB  = 25;
    localparam int ADDR_MSB = 24;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Opcodes; 3'b100 and 3'b111 are accepted and behave as NOP
    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_WRITE     = 3'b001;
    localparam logic [2:0] OP_READ      = 3'b010;
    localparam logic [2:0] OP_SET_PTR   = 3'b011;
    localparam logic [2:0] OP_WRITE_INC = 3'b101;
    localparam logic [2:0] OP_READ_INC  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    // True for any opcode that touches the SRAM
    function automatic logic op_is_access(input logic [2:0] op);
        return (op == OP_WRITE) || (op == OP_READ) ||
               (op == OP_WRITE_INC) || (op == OP_READ_INC);
    endfunction

    // True for the two write-class opcodes
    function automatic logic op_is_write(input logic [2:0] op);
        return (op == OP_WRITE) || (op == OP_WRITE_INC);
    endfunction

    // True for the pointer-addressed opcodes
    function automatic logic op_is_inc(input logic [2:0] op);
        return (op == OP_WRITE_INC) || (op == OP_READ_INC);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Command/response channel between the SPI front end (master) and the
// SRAM controller (slave): one command word per valid/ready handshake,
// read bytes returned with a one-cycle rd_valid pulse.
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_word;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_word,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_word,
        output cmd_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter that times the STROBE phase of an SRAM access.
// Loaded during SETUP, counts while enabled and flags the final strobe cycle.
module sram_strobe_timer #(
    parameter int STROBE_CYC = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STROBE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count down from STROBE_CYC-1 to zero; zero marks the last strobe cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// SRAM command controller: executes command words from the SPI front end
// against a 128Kx8 asynchronous SRAM using an IDLE/SETUP/STROBE/HOLD cycle.
// Every SRAM pin and handshake output comes straight from a register.
// Optional feature macro: SRAM_CTRL_AUTOINC_EN adds the address pointer used
// by SET_PTR / WRITE_INC / READ_INC; without it SET_PTR is a NOP and the _INC
// opcodes use the command address like plain WRITE/READ.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rstn,
    sram_ctrl_if.slave        bus,
    output logic              cen,
    output logic              oen,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    state_e state, state_next;

    logic [2:0]        opc;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] acc_addr;
    logic              accept;
    logic              acc_access;
    logic              acc_write;

    logic              cur_write;
    logic [DATA_W-1:0] wdata_q;
    logic              data_oe;
    logic              strobe_last;
    logic              wr_ctx;

    logic cen_d, oen_d, wen_d, oe_d, rd_valid_d, ready_d;

    assign opc        = bus.cmd_word[OPC_MSB:OPC_LSB];
    assign cmd_addr   = ADDR_W'(bus.cmd_word[ADDR_MSB:ADDR_LSB]);
    assign cmd_data   = DATA_W'(bus.cmd_word[DATA_MSB:DATA_LSB]);
    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign acc_access = op_is_access(opc);
    assign acc_write  = op_is_write(opc);

    sram_strobe_timer #(
        .STROBE_CYC (STROBE_CYC)
    ) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (state == ST_SETUP),
        .en   (state == ST_STROBE),
        .last (strobe_last)
    );

`ifdef SRAM_CTRL_AUTOINC_EN
    logic [ADDR_W-1:0] ptr;
    logic              cur_inc;

    // Pointer-addressed opcodes take the pointer instead of the command address
    always_comb begin
        acc_addr = op_is_inc(opc) ? ptr : cmd_addr;
    end

    // Pointer loads on SET_PTR and advances as an _INC access leaves HOLD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr     <= '0;
            cur_inc <= 1'b0;
        end else begin
            if (accept && acc_access) begin
                cur_inc <= op_is_inc(opc);
            end
            if (accept && (opc == OP_SET_PTR)) begin
                ptr <= cmd_addr;
            end else if ((state == ST_HOLD) && cur_inc) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end
`else
    // Without the pointer every access uses the command address
    always_comb begin
        acc_addr = cmd_addr;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only SRAM accesses leave IDLE
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE:   if (accept && acc_access) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: if (strobe_last) state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state; registered below so pins stay glitch-free
    always_comb begin
        wr_ctx     = (state == ST_IDLE) ? acc_write : cur_write;
        cen_d      = 1'b1;
        oen_d      = 1'b1;
        wen_d      = 1'b1;
        oe_d       = 1'b0;
        rd_valid_d = 1'b0;
        ready_d    = 1'b0;
        case (state_next)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_SETUP: begin
                cen_d = 1'b0;
                oen_d = wr_ctx;
                oe_d  = wr_ctx;
            end
            ST_STROBE: begin
                cen_d = 1'b0;
                oen_d = wr_ctx;
                wen_d = !wr_ctx;
                oe_d  = wr_ctx;
            end
            ST_HOLD: begin
                cen_d      = 1'b0;
                oe_d       = wr_ctx;
                rd_valid_d = !wr_ctx;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // Access context captured at acceptance: direction and write byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_write <= 1'b0;
            wdata_q   <= '0;
        end else if (accept && acc_access) begin
            cur_write <= acc_write;
            wdata_q   <= cmd_data;
        end
    end

    // Registered SRAM pins and handshake outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cen           <= 1'b1;
            oen           <= 1'b1;
            wen           <= 1'b1;
            data_oe       <= 1'b0;
            addr          <= '0;
            bus.rd_valid  <= 1'b0;
            bus.cmd_ready <= 1'b0;
        end else begin
            cen           <= cen_d;
            oen           <= oen_d;
            wen           <= wen_d;
            data_oe       <= oe_d;
            bus.rd_valid  <= rd_valid_d;
            bus.cmd_ready <= ready_d;
            if (accept && acc_access) begin
                addr <= acc_addr;
            end
        end
    end

    // Read byte captured on the final strobe edge, held until the next read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rd_data <= '0;
        end else if ((state == ST_STROBE) && strobe_last && !cur_write) begin
            bus.rd_data <= data;
        end
    end

    assign data = data_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: an SRAM array model on the pins, a
// behavioural memory/pointer reference model, and a monitor that pops
// expected writes and reads from scoreboard queues as the DUT performs them.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int STROBE_CYC = 2;
    localparam int MEM_N      = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                acc;
    } exp_t;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic              cen, oen, wen;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data;

    sram_ctrl_if #(.DATA_W(DATA_W)) bus ();

    sram_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STROBE_CYC (STROBE_CYC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .cen  (cen),
        .oen  (oen),
        .wen  (wen),
        .addr (addr),
        .data (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM pin model: drives the bus whenever selected with output enabled
    logic [DATA_W-1:0] sram [MEM_N];
    assign data = (!cen && !oen) ? sram[addr] : {DATA_W{1'bz}};

    int total = 0;
    int bad   = 0;
    int bus_act = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [int];
    logic [ADDR_W-1:0] ref_ptr = '0;
    exp_t exp_rd_q[$];
    exp_t exp_wr_q[$];

    function automatic logic [DATA_W-1:0] pattern(input int i);
        return 8'((i * 37) ^ (i >> 8));
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pattern(int'(a));
    endfunction

    task automatic model_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int acc);
        logic [ADDR_W-1:0] ea;
        ea = a;
`ifdef SRAM_CTRL_AUTOINC_EN
        if (op == OP_SET_PTR) ref_ptr = a;
        if (op == OP_WRITE_INC || op == OP_READ_INC) begin
            ea      = ref_ptr;
            ref_ptr = ref_ptr + 1'b1;
        end
`endif
        if (op == OP_WRITE || op == OP_WRITE_INC) begin
            exp_wr_q.push_back('{ea, d, acc});
            ref_mem[int'(ea)] = d;
        end else if (op == OP_READ || op == OP_READ_INC) begin
            exp_rd_q.push_back('{ea, ref_read(ea), acc});
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Present a command, wait (bounded) for acceptance; acc = acceptance edge index
    task automatic send(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit model_it, output int acc);
        int  n;
        bit  is_acc;
        n      = 0;
        is_acc = (op == OP_WRITE) || (op == OP_READ) || (op == OP_WRITE_INC) || (op == OP_READ_INC);
        bus.cmd_word  = {op, a, d};
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            fail_event("accept_timeout", "cmd_ready never rose");
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (model_it) model_cmd(op, a, d, acc);
        @(posedge clk);
        @(negedge clk);
        check(is_acc ? "ready_drop" : "ready_keep", 32'(bus.cmd_ready), 32'(!is_acc));
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        bus.cmd_valid = 1'b0;
        while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rd_queue_empty", 32'(exp_rd_q.size()), 0);
        check("wr_queue_empty", 32'(exp_wr_q.size()), 0);
    endtask

    // ---------------- monitor ----------------
    logic prev_wen = 1'b1;
    logic prev_rdv = 1'b0;
    int   wen_lo   = 0;
    exp_t cur_wr   = '{'0, '0, 0};

    always @(negedge clk) begin
        if (!rstn) begin
            prev_wen = 1'b1;
            prev_rdv = 1'b0;
            wen_lo   = 0;
        end else begin
            if (!cen) bus_act++;
            if (!wen || !oen) check("strobe_overlap", 32'(!wen && !oen), 0);
            if (!wen) begin
                if (prev_wen) begin
                    wen_lo = 0;
                    if (exp_wr_q.size() == 0) begin
                        fail_event("wr_unexpected", "write strobe with no pending write");
                    end else begin
                        cur_wr = exp_wr_q.pop_front();
                        check("wr_addr", 32'(addr), 32'(cur_wr.addr));
                        check("wr_start", 32'(cyc), 32'(cur_wr.acc + 1));
                    end
                end
                check("wr_data", 32'(data), 32'(cur_wr.data));
                sram[addr] = data;
                wen_lo++;
            end else if (!prev_wen) begin
                check("wen_low_cycles", 32'(wen_lo), STROBE_CYC);
            end
            prev_wen = wen;
            if (bus.rd_valid) begin
                check("rd_valid_pulse", 32'(prev_rdv), 0);
                if (exp_rd_q.size() == 0) begin
                    fail_event("rd_unexpected", "rd_valid with no pending read");
                end else begin
                    exp_t e;
                    e = exp_rd_q.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(e.data));
                    check("rd_latency", 32'(cyc), 32'(e.acc + STROBE_CYC + 1));
                end
            end
            prev_rdv = bus.rd_valid;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int accs[4];
        int act0;
        bus.cmd_valid = 1'b0;
        bus.cmd_word  = '0;
        for (int i = 0; i < MEM_N; i++) sram[i] = pattern(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_cen", 32'(cen), 1);
        check("reset_oen", 32'(oen), 1);
        check("reset_wen", 32'(wen), 1);
        check("reset_addr", 32'(addr), 0);
        check("reset_ready", 32'(bus.cmd_ready), 0);
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_rd_data", 32'(bus.rd_data), 0);
        #1 rstn = 1'b1;
        check("ready_before_edge", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        check("ready_after_release", 32'(bus.cmd_ready), 1);

        // Write then read back
        send(OP_WRITE, 17'h0A5A3, 8'h3C, 1'b1, acc);
        send(OP_READ, 17'h0A5A3, 8'h00, 1'b1, acc);

        // Pointer wrap sequence
        send(OP_SET_PTR, 17'h1FFFE, 8'h00, 1'b1, acc);
        send(OP_WRITE_INC, 17'h00055, 8'h11, 1'b1, acc);
        send(OP_WRITE_INC, 17'h00055, 8'h22, 1'b1, acc);
        send(OP_WRITE_INC, 17'h00055, 8'h33, 1'b1, acc);
        send(OP_READ, 17'h1FFFE, 8'h00, 1'b1, acc);
        send(OP_READ, 17'h1FFFF, 8'h00, 1'b1, acc);
        send(OP_READ, 17'h00000, 8'h00, 1'b1, acc);
        send(OP_READ_INC, 17'h00001, 8'h00, 1'b1, acc);
        send(OP_READ, 17'h00055, 8'h00, 1'b1, acc);

        // READ_INC with command address, then SET_PTR must not touch the bus
        send(OP_READ_INC, 17'h00100, 8'h00, 1'b1, acc);
        drain();
        act0 = bus_act;
        send(OP_SET_PTR, 17'h00300, 8'h00, 1'b1, acc);
        idle(6);
        check("setptr_no_bus", 32'(bus_act), 32'(act0));

        // NOPs accepted every cycle
        send(OP_NOP, 17'h0, 8'h0, 1'b1, accs[0]);
        send(3'b100, 17'h0, 8'h0, 1'b1, accs[1]);
        send(3'b111, 17'h0, 8'h0, 1'b1, accs[2]);
        check("nop_spacing_a", 32'(accs[1] - accs[0]), 1);
        check("nop_spacing_b", 32'(accs[2] - accs[1]), 1);

        // Four queued READs with cmd_valid held high
        for (int i = 0; i < 4; i++) send(OP_READ, 17'h00010 + 17'(i), 8'h00, 1'b1, accs[i]);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(accs[i] - accs[i-1]), STROBE_CYC + 3);
        drain();

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            logic [2:0]        op;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            op = 3'($urandom_range(0, 7));
            a  = 17'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = a | 17'h1FFE0;
            d  = 8'($urandom);
            send(op, a, d, 1'b1, acc);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Reset during the STROBE phase of a READ
        send(OP_READ, 17'h0A5A3, 8'h00, 1'b0, acc);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_cen", 32'(cen), 1);
        check("midrst_oen", 32'(oen), 1);
        check("midrst_wen", 32'(wen), 1);
        check("midrst_ready", 32'(bus.cmd_ready), 0);
        check("midrst_rd_valid", 32'(bus.rd_valid), 0);
        check("midrst_rd_data", 32'(bus.rd_data), 0);
        ref_ptr = '0;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("ready_after_midrst", 32'(bus.cmd_ready), 1);
        idle(4);
        check("midrst_rd_data_held", 32'(bus.rd_data), 0);

        // Recovery after reset
        send(OP_WRITE, 17'h00777, 8'hA5, 1'b1, acc);
        send(OP_READ, 17'h00777, 8'h00, 1'b1, acc);
        send(OP_READ_INC, 17'h00002, 8'h00, 1'b1, acc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
